// File: rtl/ahb_gpio_par.sv
// AHB-Lite GPIO with per-bit direction, input synchroniser, odd/even parity
// generation and checking, and sticky rising-edge interrupts.

module ahb_gpio_par_sync #(
  parameter int STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ff <= '0;
    else begin
      ff[0] <= d;
      for (int k = 1; k < STAGES; k++) ff[k] <= ff[k-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

module ahb_gpio_par_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic pad,
  input  logic dir,
  input  logic irqen,
  input  logic wr_data,
  input  logic wd,
  input  logic clr,
  output logic out_bit,
  output logic sync_bit,
  output logic stat_bit
);
  logic prev;
  logic rise;

  ahb_gpio_par_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .HCLK(HCLK), .HRESETn(HRESETn), .d(pad), .q(sync_bit)
  );

  assign rise = sync_bit & ~prev & ~dir & irqen;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prev     <= 1'b0;
      out_bit  <= 1'b0;
      stat_bit <= 1'b0;
    end else begin
      prev <= sync_bit;
      if (wr_data && dir) out_bit <= wd;
      // a new edge beats a same-cycle write-1-to-clear
      stat_bit <= rise | (stat_bit & ~clr);
    end
  end
endmodule

module ahb_gpio_par #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HWDATA,
  input  logic              HWRITE,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [DATA_W:0]   GPIOIN,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic [DATA_W:0]   GPIOOUT,
  output logic [DATA_W-1:0] GPIODIR,
  output logic              PARITYERR,
  output logic              IRQ
);
  logic [7:0]        addr_q;
  logic              trans_q, write_q, sel_q;
  logic [DATA_W-1:0] dir_q, irqen_q;
  logic              odd_q, chken_q, pstat_q;
  logic [DATA_W-1:0] out_reg, sync_data, stat;
  logic              sync_par;
  logic              wr_en, wr_data, wr_dir, wr_cfg, wr_ien, wr_stat;
  logic [DATA_W-1:0] clr;
  logic              perr_d;
  logic              unused_ok;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      trans_q <= 1'b0;
      write_q <= 1'b0;
      sel_q   <= 1'b0;
    end else if (HREADY) begin
      addr_q  <= HADDR[7:0];
      trans_q <= HTRANS[1];
      write_q <= HWRITE;
      sel_q   <= HSEL;
    end
  end

  assign wr_en   = sel_q & write_q & trans_q;
  assign wr_data = wr_en && (addr_q == 8'h00);
  assign wr_dir  = wr_en && (addr_q == 8'h04);
  assign wr_cfg  = wr_en && (addr_q == 8'h08);
  assign wr_ien  = wr_en && (addr_q == 8'h0C);
  assign wr_stat = wr_en && (addr_q == 8'h10);
  assign clr     = wr_stat ? HWDATA[DATA_W-1:0] : '0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_lane
    ahb_gpio_par_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .HCLK(HCLK), .HRESETn(HRESETn), .pad(GPIOIN[i]), .dir(dir_q[i]),
      .irqen(irqen_q[i]), .wr_data(wr_data), .wd(HWDATA[i]), .clr(clr[i]),
      .out_bit(out_reg[i]), .sync_bit(sync_data[i]), .stat_bit(stat[i])
    );
  end

  ahb_gpio_par_sync #(.STAGES(SYNC_STAGES)) u_par_sync (
    .HCLK(HCLK), .HRESETn(HRESETn), .d(GPIOIN[DATA_W]), .q(sync_par)
  );

  // checking only makes sense when every pin is an input
  assign perr_d = chken_q && (dir_q == '0) &&
                  (sync_par != (odd_q ? ~^sync_data : ^sync_data));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dir_q     <= '0;
      irqen_q   <= '0;
      odd_q     <= 1'b0;
      chken_q   <= 1'b0;
      PARITYERR <= 1'b0;
      pstat_q   <= 1'b0;
    end else begin
      if (wr_dir) dir_q <= HWDATA[DATA_W-1:0];
      if (wr_ien) irqen_q <= HWDATA[DATA_W-1:0];
      if (wr_cfg) begin
        odd_q   <= HWDATA[0];
        chken_q <= HWDATA[1];
      end
      PARITYERR <= perr_d;
      pstat_q   <= perr_d | (pstat_q & ~(wr_stat & HWDATA[DATA_W]));
    end
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      8'h00: HRDATA[DATA_W-1:0] = (out_reg & dir_q) | (sync_data & ~dir_q);
      8'h04: HRDATA[DATA_W-1:0] = dir_q;
      8'h08: HRDATA[1:0]        = {chken_q, odd_q};
      8'h0C: HRDATA[DATA_W-1:0] = irqen_q;
      8'h10: HRDATA[DATA_W:0]   = {pstat_q, stat};
      default: HRDATA = '0;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = {odd_q ? ~^out_reg : ^out_reg, out_reg};
  assign GPIODIR   = dir_q;
  assign IRQ       = pstat_q | (|stat);
  assign unused_ok = ^{HADDR[31:8], HTRANS[0], HWDATA};
endmodule
